// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (SEXT/ZEXT/UPPER/SEXT_SHL2) with valid/ready and a 2-entry skid.
// Optional accepted-input counter enabled by defining IMM_EXT_CNT_EN.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data
`ifdef IMM_EXT_CNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt
`endif
);

    function automatic logic [OUT_W-1:0] f_extend(input logic [IN_W-1:0] imm, input logic [1:0] mode);
        logic [OUT_W-1:0] sext;
        sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
        case (mode)
            2'b00:   f_extend = sext;
            2'b01:   f_extend = {{(OUT_W-IN_W){1'b0}}, imm};
            2'b10:   f_extend = {imm, {(OUT_W-IN_W){1'b0}}};
            2'b11:   f_extend = {sext[OUT_W-3:0], 2'b00};
            default: f_extend = sext;
        endcase
    endfunction

    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_skid_valid;
    logic [OUT_W-1:0] r_skid_data;
    logic             r_in_ready;

    logic             w_in_xfer;
    logic             w_out_free;
    logic [OUT_W-1:0] w_ext;
    logic             w_out_valid_nxt;
    logic [OUT_W-1:0] w_out_data_nxt;
    logic             w_skid_valid_nxt;
    logic [OUT_W-1:0] w_skid_data_nxt;

    // Next-state for output stage and skid entry; skid always drains before new input.
    always_comb begin
        w_in_xfer        = in_valid & r_in_ready;
        w_out_free       = !r_out_valid | out_ready;
        w_ext            = f_extend(in_imm, in_mode);
        w_out_valid_nxt  = r_out_valid;
        w_out_data_nxt   = r_out_data;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (w_out_free) begin
            if (r_skid_valid) begin
                w_out_valid_nxt  = 1'b1;
                w_out_data_nxt   = r_skid_data;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_xfer) begin
                w_out_valid_nxt  = 1'b1;
                w_out_data_nxt   = w_ext;
            end else begin
                w_out_valid_nxt  = 1'b0;
            end
        end else begin
            if (w_in_xfer) begin
                w_skid_valid_nxt = 1'b1;
                w_skid_data_nxt  = w_ext;
            end else begin
                w_skid_valid_nxt = r_skid_valid;
            end
        end
    end

    // Pipeline registers; in_ready is registered from the next skid occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= {OUT_W{1'b0}};
            r_skid_valid <= 1'b0;
            r_skid_data  <= {OUT_W{1'b0}};
            r_in_ready   <= 1'b1;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

`ifdef IMM_EXT_CNT_EN
    logic [CNT_W-1:0] r_xfer_cnt;

    // Counts accepted inputs, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xfer_cnt <= {CNT_W{1'b0}};
        end else if (w_in_xfer) begin
            r_xfer_cnt <= r_xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_xfer_cnt <= r_xfer_cnt;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
